// File: rtl/mix_pkg.sv
// Shared types and constants for the lane-mixing engine.
// Holds the FSM state enum, default sizes and per-lane constants.
package mix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEF_N          = 8;
    localparam int DEF_W          = 32;
    localparam int DEF_SH         = 16;
    localparam int DEF_MAX_ROUNDS = 15;

    // Odd multiplier per lane keeps step C invertible mod 2^W.
    function automatic int lane_mul(input int i);
        return 2 * i + 3;
    endfunction

    function automatic int lane_add(input int i);
        return i + 1;
    endfunction

endpackage

// File: rtl/mix_round.sv
// One combinational mixing round over N lanes of W bits.
// Ports: lanes_in (N*W, lane i at [i*W +: W]) -> lanes_out (same packing).
module mix_round
    import mix_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int SH = DEF_SH
) (
    input  logic [N*W-1:0] lanes_in,
    output logic [N*W-1:0] lanes_out
);

    logic [N-1:0][W-1:0] x;
    logic [N-1:0][W-1:0] a;
    logic [N-1:0][W-1:0] b;
    logic [N-1:0][W-1:0] c;

    assign x = lanes_in;

    for (genvar i = 0; i < N; i++) begin : g_lane
        // Step A chains through the already-updated lower lane;
        // lane 0 wraps to the original top lane.
        if (i == 0) begin : g_a0
            assign a[i] = x[i] + x[N-1];
        end else begin : g_an
            assign a[i] = x[i] + a[i-1] + W'(i);
        end

        // Step B: the top lane sees the already-updated lane 0.
        if (i == N - 1) begin : g_bt
            assign b[i] = a[i] ^ (b[0] << SH);
        end else begin : g_bn
            assign b[i] = a[i] ^ (a[i+1] << SH);
        end

        assign c[i] = b[i] * W'(lane_mul(i)) + W'(lane_add(i));
    end

    assign lanes_out = c;

endmodule

// File: rtl/mix_round_engine.sv
// Handshaked iterative mixing engine: loads N lanes, runs up to
// MAX_ROUNDS rounds (one per clock), then presents the result.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_data/in_rounds
// job input; out_valid/out_ready/out_data result; busy in RUN/DONE.
module mix_round_engine
    import mix_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int W          = DEF_W,
    parameter int SH         = DEF_SH,
    parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
    parameter int RW         = $clog2(MAX_ROUNDS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [RW-1:0] in_rounds,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N*W-1:0] out_data,
    output logic          busy
);

    localparam logic [RW-1:0] CMAX = RW'(MAX_ROUNDS);

    state_t         state;
    logic [RW-1:0]  cnt;
    logic [RW-1:0]  cnt_ld;
    logic [N*W-1:0] lanes;
    logic [N*W-1:0] nxt;
    logic           rdy_q;
    logic           vld_q;
    logic           busy_q;

    assign cnt_ld = (in_rounds > CMAX) ? CMAX : in_rounds;

    mix_round #(
        .N  (N),
        .W  (W),
        .SH (SH)
    ) u_round (
        .lanes_in  (lanes),
        .lanes_out (nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            lanes  <= '0;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && rdy_q) begin
                        lanes  <= in_data;
                        cnt    <= cnt_ld;
                        rdy_q  <= 1'b0;
                        busy_q <= 1'b1;
                        // Zero rounds: result is the loaded data.
                        if (cnt_ld == '0) begin
                            state <= DONE;
                            vld_q <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    lanes <= nxt;
                    cnt   <= cnt - RW'(1);
                    if (cnt == RW'(1)) begin
                        state <= DONE;
                        vld_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state  <= IDLE;
                        vld_q  <= 1'b0;
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    vld_q  <= 1'b0;
                    rdy_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign busy      = busy_q;
    assign out_data  = lanes;

endmodule

// File: tb/tb_mix_round_engine.sv
// Directed bench for mix_round_engine: a 4x8 instance with hand-worked
// vectors and an 8x32 instance checked against a behavioural model.
module tb_mix_round_engine;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // small instance: N=4, W=8, SH=4
    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_in_data;
    logic [3:0]  s_in_rounds;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [31:0] s_out_data;
    logic        s_busy;

    // default lanes, widened round input so 20 can be offered
    logic         b_in_valid;
    logic         b_in_ready;
    logic [255:0] b_in_data;
    logic [4:0]   b_in_rounds;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [255:0] b_out_data;
    logic         b_busy;

    int checks = 0;
    int errors = 0;

    mix_round_engine #(
        .N  (4),
        .W  (8),
        .SH (4)
    ) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .in_rounds (s_in_rounds),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .busy      (s_busy)
    );

    mix_round_engine #(
        .RW (5)
    ) u_big (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_rounds (b_in_rounds),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .busy      (b_busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model(input logic [255:0] d,
                                           input int r);
        logic [31:0]  x [8];
        logic [255:0] o;
        for (int i = 0; i < 8; i++) x[i] = d[i*32 +: 32];
        for (int k = 0; k < r; k++) begin
            for (int i = 0; i < 8; i++)
                x[i] = x[i] + x[(i + 7) % 8] + 32'(i);
            for (int i = 0; i < 8; i++)
                x[i] = x[i] ^ (x[(i + 1) % 8] << 16);
            for (int i = 0; i < 8; i++)
                x[i] = x[i] * 32'(2 * i + 3) + 32'(i + 1);
        end
        o = '0;
        for (int i = 0; i < 8; i++) o[i*32 +: 32] = x[i];
        return o;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one job on the small instance; n = edges until out_valid.
    task automatic job_s(input logic [31:0] d, input logic [3:0] r,
                         output int n);
        s_in_data   = d;
        s_in_rounds = r;
        s_in_valid  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            s_in_valid = 1'b0;
        end while (!s_out_valid && n < 100);
    endtask

    // Offer one job on the big instance; with hold, in_valid stays
    // high with junk data that must not be accepted.
    task automatic job_b(input logic [255:0] d, input logic [4:0] r,
                         input bit hold, output int n);
        b_in_data   = d;
        b_in_rounds = r;
        b_in_valid  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            b_in_valid = hold;
            if (hold) begin
                b_in_data   = rnd256();
                b_in_rounds = 5'($urandom_range(0, 31));
            end
        end while (!b_out_valid && n < 100);
    endtask

    initial begin
        int           n;
        int           r;
        int           rr;
        logic [255:0] d;
        logic [255:0] cap;

        rst_n       = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_in_rounds = '0;
        s_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_rounds = '0;
        b_out_ready = 1'b0;

        repeat (2) tick();
        chk("rst_s_ready", 256'(s_in_ready), 256'(1));
        chk("rst_s_valid", 256'(s_out_valid), 256'(0));
        chk("rst_s_busy", 256'(s_busy), 256'(0));
        chk("rst_s_data", 256'(s_out_data), 256'(0));
        chk("rst_b_ready", 256'(b_in_ready), 256'(1));
        chk("rst_b_data", b_out_data, 256'(0));
        rst_n = 1'b1;
        tick();
        chk("post_rst_b_valid", 256'(b_out_valid), 256'(0));

        // zero lanes, one round: hand-worked result 3A B8 F7 31
        job_s(32'h0, 4'd1, n);
        chk("s1_valid", 256'(s_out_valid), 256'(1));
        chk("s1_latency", 256'(n), 256'(2));
        chk("s1_data", 256'(s_out_data), 256'(32'h3AB8F731));
        chk("s1_busy", 256'(s_busy), 256'(1));
        chk("s1_ready_low", 256'(s_in_ready), 256'(0));
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk("s1_idle_ready", 256'(s_in_ready), 256'(1));
        chk("s1_idle_valid", 256'(s_out_valid), 256'(0));

        // zero rounds: pass-through
        job_s(32'h04030201, 4'd0, n);
        chk("s0_latency", 256'(n), 256'(1));
        chk("s0_data", 256'(s_out_data), 256'(32'h04030201));
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;

        // five rounds with back-pressure
        d = rnd256();
        job_b(d, 5'd5, 1'b0, n);
        chk("b5_latency", 256'(n), 256'(6));
        chk("b5_data", b_out_data, model(d, 5));
        cap = model(d, 5);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("b5_hold_data", b_out_data, cap);
            chk("b5_hold_ready", 256'(b_in_ready), 256'(0));
            chk("b5_hold_valid", 256'(b_out_valid), 256'(1));
        end
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        chk("b5_rel_ready", 256'(b_in_ready), 256'(1));
        chk("b5_rel_valid", 256'(b_out_valid), 256'(0));
        chk("b5_rel_busy", 256'(b_busy), 256'(0));

        // over-range round count clamps to 15
        d = rnd256();
        job_b(d, 5'd20, 1'b0, n);
        chk("b20_latency", 256'(n), 256'(16));
        chk("b20_data", b_out_data, model(d, 15));
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;

        // asynchronous reset in the middle of RUN
        b_in_data   = rnd256();
        b_in_rounds = 5'd10;
        b_in_valid  = 1'b1;
        tick();
        b_in_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy_pre", 256'(b_busy), 256'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 256'(b_out_valid), 256'(0));
        chk("mid_busy", 256'(b_busy), 256'(0));
        chk("mid_ready", 256'(b_in_ready), 256'(1));
        chk("mid_data", b_out_data, 256'(0));
        rst_n = 1'b1;
        tick();
        repeat (12) tick();
        chk("mid_no_output", 256'(b_out_valid), 256'(0));
        d = rnd256();
        job_b(d, 5'd3, 1'b0, n);
        chk("mid_new_latency", 256'(n), 256'(4));
        chk("mid_new_data", b_out_data, model(d, 3));
        b_out_ready = 1'b1;
        tick();

        // back-to-back jobs, in_valid held high throughout
        for (int j = 0; j < 6; j++) begin
            d  = rnd256();
            r  = $urandom_range(0, 20);
            rr = (r > 15) ? 15 : r;
            chk("bb_ready", 256'(b_in_ready), 256'(1));
            job_b(d, 5'(r), 1'b1, n);
            chk("bb_latency", 256'(n), 256'(rr + 1));
            chk("bb_data", b_out_data, model(d, rr));
            tick();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
